// File: rtl/lcd_responder.sv
// lcd_responder: display-side model of an HD44780-style 8-bit LCD bus.
// Transfers are taken on the falling edge of EN. Commands update the control
// state and the cursor address. Character writes go into an 80-byte DDRAM.
// A registered read port mirrors the DDRAM contents for inspection.
//
// Ports:
//   clk, rst           system clock; synchronous active-high reset
//   EN, RS, data       LCD bus: enable strobe, register select, byte
//   rd_addr / rd_data  DDRAM physical index readback (1-cycle latency)
//   busy               high during clear and for BUSY_CYCLES after a transfer
//   addr               current DDRAM address (0x00-0x27 / 0x40-0x67)
//   display_on, cursor_on, blink_on, inc_mode   control state
//   char_valid, last_char                       character store pulse / value
//   ovf_err, cmd_err                            dropped-transfer / bad-address pulses
module lcd_responder #(
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned DDRAM_DEPTH = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       RS,
  input  logic [7:0] data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       char_valid,
  output logic [7:0] last_char,
  output logic       ovf_err,
  output logic       cmd_err
);

  localparam int unsigned CW     = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [6:0]  DEPTH7 = 7'(DDRAM_DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, EXEC} state_t;

  state_t        state, state_d;
  logic [6:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          en_q;
  logic          xfer;

  logic [6:0]    addr_d;
  logic          disp_d, curs_d, blink_d, inc_d, cv_d, ovf_d, cerr_d;
  logic [7:0]    last_d;

  logic          we;
  logic [6:0]    waddr;
  logic [7:0]    wdata;

  logic [7:0]    mem [DDRAM_DEPTH];

  // Map HD44780 address to linear DDRAM index (line 2 follows line 1).
  function automatic logic [6:0] phys(input logic [6:0] a);
    return (a < 7'h40) ? a : a - 7'd24;
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  assign xfer = en_q & ~EN;
  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    addr_d  = addr;
    disp_d  = display_on;
    curs_d  = cursor_on;
    blink_d = blink_on;
    inc_d   = inc_mode;
    last_d  = last_char;
    cv_d    = 1'b0;
    ovf_d   = 1'b0;
    cerr_d  = 1'b0;
    we      = 1'b0;
    waddr   = idx;
    wdata   = 8'h20;

    unique case (state)
      CLEAR: begin
        we    = ~rst;
        ovf_d = xfer;
        if (idx == DEPTH7 - 7'd1) begin
          state_d = IDLE;
          idx_d   = '0;
          addr_d  = '0;
          inc_d   = 1'b1;
        end else begin
          idx_d = idx + 7'd1;
        end
      end

      EXEC: begin
        ovf_d = xfer;
        if (cnt == CW'(BUSY_CYCLES - 1)) state_d = IDLE;
        else                             cnt_d   = cnt + CW'(1);
      end

      IDLE: begin
        if (xfer) begin
          state_d = EXEC;
          cnt_d   = '0;
          if (RS) begin
            we     = ~rst;
            waddr  = phys(addr);
            wdata  = data;
            last_d = data;
            cv_d   = 1'b1;
            addr_d = step(addr, inc_mode);
          end else begin
            casez (data)
              8'b1???????: begin
                if (addr_ok(data[6:0])) addr_d = data[6:0];
                else                    cerr_d = 1'b1;
              end
              8'b01??????, 8'b001?????, 8'b0001????: begin
              end
              8'b00001???: begin
                disp_d  = data[2];
                curs_d  = data[1];
                blink_d = data[0];
              end
              8'b000001??: inc_d  = data[1];
              8'b0000001?: addr_d = '0;
              8'b00000001: begin
                state_d = CLEAR;
                idx_d   = '0;
              end
              default: begin
              end
            endcase
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      idx        <= '0;
      cnt        <= '0;
      en_q       <= 1'b0;
      addr       <= '0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc_mode   <= 1'b1;
      last_char  <= '0;
      char_valid <= 1'b0;
      ovf_err    <= 1'b0;
      cmd_err    <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      en_q       <= EN;
      addr       <= addr_d;
      display_on <= disp_d;
      cursor_on  <= curs_d;
      blink_on   <= blink_d;
      inc_mode   <= inc_d;
      last_char  <= last_d;
      char_valid <= cv_d;
      ovf_err    <= ovf_d;
      cmd_err    <= cerr_d;
      // Read-before-write: a same-cycle DDRAM write is not yet visible here.
      rd_data    <= (rd_addr < DEPTH7) ? mem[rd_addr] : 8'h00;
    end
  end

  // DDRAM contents are not reset; the post-reset clear initialises them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_lcd_responder.sv
module tb_lcd_responder;
  localparam int unsigned BC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic [6:0] rd_addr = 7'd0;
  logic [7:0] rd_data, last_char;
  logic [6:0] addr;
  logic       busy, display_on, cursor_on, blink_on, inc_mode;
  logic       char_valid, ovf_err, cmd_err;

  lcd_responder #(.BUSY_CYCLES(BC), .DDRAM_DEPTH(80)) dut (
    .clk(clk), .rst(rst), .EN(en), .RS(rs), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .addr(addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .char_valid(char_valid), .last_char(last_char),
    .ovf_err(ovf_err), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: linear 80-cell display, countdowns for busy periods.
  logic [7:0] mem_m [80];
  bit         ok_m  [80];
  int         clr_left = 0, exec_left = 0;
  bit         enq_m, d_m, c_m, b_m, i_m, cv_m, ovf_m, ce_m, rd_known;
  logic [6:0] addr_m;
  logic [7:0] last_m, rd_m;
  bit         pin_rd = 0;

  function automatic int pos_of(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
  endfunction

  function automatic logic [6:0] addr_of(input int p);
    return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
  endfunction

  task automatic model_edge();
    bit x;
    int p;
    if (rst) begin
      clr_left = 80; exec_left = 0; enq_m = 0; addr_m = 0;
      d_m = 0; c_m = 0; b_m = 0; i_m = 1; last_m = 0;
      cv_m = 0; ovf_m = 0; ce_m = 0; rd_m = 0; rd_known = 1;
      return;
    end
    x = enq_m && !en;
    enq_m = en;
    cv_m = 0; ovf_m = 0; ce_m = 0;
    if (rd_addr >= 7'd80) begin rd_m = 0; rd_known = 1; end
    else begin rd_m = mem_m[rd_addr]; rd_known = ok_m[rd_addr]; end
    if (clr_left > 0) begin
      p = 80 - clr_left;
      mem_m[p] = 8'h20; ok_m[p] = 1;
      clr_left--;
      if (clr_left == 0) begin addr_m = 0; i_m = 1; end
      ovf_m = x;
    end else if (exec_left > 0) begin
      exec_left--;
      ovf_m = x;
    end else if (x) begin
      exec_left = BC;
      if (rs) begin
        p = pos_of(addr_m);
        mem_m[p] = data; ok_m[p] = 1;
        last_m = data; cv_m = 1;
        p = i_m ? (p + 1) % 80 : (p + 79) % 80;
        addr_m = addr_of(p);
      end else if (data >= 8'h80) begin
        if (data[6:0] <= 7'h27 || (data[6:0] >= 7'h40 && data[6:0] <= 7'h67)) addr_m = data[6:0];
        else ce_m = 1;
      end else if (data >= 8'h10) begin
      end else if (data >= 8'h08) begin
        d_m = data[2]; c_m = data[1]; b_m = data[0];
      end else if (data >= 8'h04) begin
        i_m = data[1];
      end else if (data >= 8'h02) begin
        addr_m = 0;
      end else if (data == 8'h01) begin
        exec_left = 0; clr_left = 80;
      end
    end
  endtask

  task automatic compare_all();
    check("busy", 8'(busy), 8'(clr_left > 0 || exec_left > 0));
    check("addr", 8'(addr), 8'(addr_m));
    check("ctrl", {4'h0, display_on, cursor_on, blink_on, inc_mode}, {4'h0, d_m, c_m, b_m, i_m});
    check("char_valid", 8'(char_valid), 8'(cv_m));
    check("last_char", last_char, last_m);
    check("ovf_err", 8'(ovf_err), 8'(ovf_m));
    check("cmd_err", 8'(cmd_err), 8'(ce_m));
    if (rd_known) check("rd_data", rd_data, rd_m);
  endtask

  task automatic cyc(input bit e, input bit r, input logic [7:0] d);
    @(negedge clk);
    en = e; rs = r; data = d;
    if (!pin_rd) rd_addr = 7'($urandom_range(0, 95));
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic xfer(input bit r, input logic [7:0] d);
    cyc(1, r, d);
    cyc(0, r, d);
  endtask

  task automatic wait_ready();
    while (clr_left > 0 || exec_left > 0) cyc(0, 0, 8'h00);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      cyc(0, 0, 8'h00);
    end
  endtask

  task automatic peek(input logic [6:0] a, input logic [7:0] e, input string tag);
    pin_rd = 1;
    rd_addr = a;
    cyc(0, 0, 8'h00);
    check(tag, rd_data, e);
    pin_rd = 0;
  endtask

  initial begin
    int n, ncv;
    logic [7:0] str [4];
    str[0] = 8'h4C; str[1] = 8'h4F; str[2] = 8'h41; str[3] = 8'h44;

    // Reset and mandatory clear
    rst = 1;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    rst = 0;
    count_busy(n);
    check("post_reset_clear_len", 8'(n), 8'd80);
    for (int i = 0; i < 80; i++) peek(7'(i), 8'h20, "clear_fill");
    check("addr_after_clear", 8'(addr), 8'h00);

    // Driver init sequence
    xfer(0, 8'h38); wait_ready();
    xfer(0, 8'h0E); wait_ready();
    check("disp_ctrl", {5'h0, display_on, cursor_on, blink_on}, 8'h06);
    xfer(0, 8'h01);
    count_busy(n);
    check("clear_cmd_len", 8'(n), 8'd80);
    xfer(0, 8'h02); wait_ready();
    check("addr_home", 8'(addr), 8'h00);

    // "LOAD"
    ncv = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1, str[i]);
      if (char_valid === 1'b1) ncv++;
      wait_ready();
    end
    check("cv_count", 8'(ncv), 8'd4);
    check("last_char_load", last_char, 8'h44);
    check("addr_load", 8'(addr), 8'h04);
    for (int i = 0; i < 4; i++) peek(7'(i), str[i], "load_text");

    // Wrap cases
    xfer(0, 8'hA7); wait_ready();
    xfer(1, 8'h31);
    check("wrap_27_40", 8'(addr), 8'h40);
    wait_ready();
    peek(7'd39, 8'h31, "ddram39");
    xfer(0, 8'hE7); wait_ready();
    xfer(1, 8'h32);
    check("wrap_67_00", 8'(addr), 8'h00);
    wait_ready();
    peek(7'd79, 8'h32, "ddram79");

    // Overflow and bad address
    xfer(1, 8'h58);
    xfer(1, 8'h59);
    check("ovf_pulse", 8'(ovf_err), 8'd1);
    wait_ready();
    check("addr_after_ovf", 8'(addr), 8'h01);
    peek(7'd0, 8'h58, "ddram_after_ovf");
    xfer(0, 8'hB0);
    check("cmd_err_pulse", 8'(cmd_err), 8'd1);
    check("addr_after_cmd_err", 8'(addr), 8'h01);
    wait_ready();

    // Decrement across line boundary
    xfer(0, 8'h04); wait_ready();
    xfer(0, 8'hC0); wait_ready();
    xfer(1, 8'h33);
    check("wrap_40_27", 8'(addr), 8'h27);
    wait_ready();
    peek(7'd40, 8'h33, "ddram40");

    // Randomized traffic, including collisions and long EN highs
    for (int it = 0; it < 400; it++) begin
      bit r;
      logic [7:0] d;
      r = ($urandom_range(0, 9) < 6);
      d = 8'($urandom_range(0, 255));
      if (!r && d == 8'h01 && $urandom_range(0, 1) == 0) d = 8'h0F;
      repeat ($urandom_range(0, 2)) cyc(1, r, d);
      xfer(r, d);
      repeat ($urandom_range(0, 6)) cyc(0, 0, 8'h00);
    end
    wait_ready();

    // Reset in the middle of a clear
    xfer(0, 8'h0F); wait_ready();
    xfer(0, 8'h01);
    repeat (20) cyc(0, 0, 8'h00);
    rst = 1;
    cyc(0, 0, 8'h00);
    rst = 0;
    check("rst_ctrl", {4'h0, display_on, cursor_on, blink_on, inc_mode}, 8'h01);
    check("rst_rd", rd_data, 8'h00);
    count_busy(n);
    check("rst_mid_clear_len", 8'(n), 8'd80);
    for (int i = 0; i < 80; i += 13) peek(7'(i), 8'h20, "refill");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Synthesizable HD44780-subset responder: the display end of the 8-bit LCD bus (data/EN/RS) that our LCD driver masters.
- Latches commands and characters on the EN falling edge and maintains an 80-byte DDRAM plus control state.
- Models busy timing and exposes a registered DDRAM read port.
- Used as an on-chip display mirror and as the checker-side model in driver benches.

Parameters:
- BUSY_CYCLES, 4, cycles busy stays high after any accepted non-clear command or data write (must be >=1).
- DDRAM_DEPTH, 80, DDRAM bytes (two lines of 40); fixed at 80 for this revision.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- EN  in  1  LCD enable strobe from driver; transfer is taken on its falling edge
- RS  in  1  0 = command, 1 = character data
- data  in  8  LCD bus byte
- rd_addr  in  7  DDRAM physical index 0..79 for readback
- rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency
- busy  out  1  busy flag
- addr  out  7  current DDRAM address (HD44780 encoding 0x00-0x27 / 0x40-0x67)
- display_on  out  1  display control D bit
- cursor_on  out  1  display control C bit
- blink_on  out  1  display control B bit
- inc_mode  out  1  entry mode I/D (1 = increment)
- char_valid  out  1  1-cycle pulse when a character is stored
- last_char  out  8  last stored character
- ovf_err  out  1  1-cycle pulse when a transfer is dropped because busy
- cmd_err  out  1  1-cycle pulse on a Set DDRAM Address with an unmapped address

Behaviour:
- Edge detect: en_q is EN registered. A transfer occurs on a cycle where en_q=1 and EN=0; RS and data are sampled on that same edge. EN held high, or held low, produces no transfer.
- FSM states:
  - CLEAR: walk DDRAM index 0..79, writing 0x20 one per cycle (80 cycles). Then addr=0, inc_mode=1, go to IDLE.
  - IDLE: busy=0. A transfer is decoded on the detect cycle.
  - EXEC: busy=1 and a counter runs BUSY_CYCLES cycles, then IDLE.
- Reset (asserted any cycle, including mid-CLEAR or mid-EXEC):
  - Enters CLEAR with index 0 and busy=1.
  - display_on=cursor_on=blink_on=0, inc_mode=1, addr=0, last_char=0x00, char_valid=ovf_err=cmd_err=0, rd_data=0x00, en_q=0.
  - The post-reset CLEAR is mandatory: busy stays high for 80 cycles after rst falls.
- Command decode (RS=0), priority from MSB down. Every command except clear goes to EXEC.
  - 1xxxxxxx: Set DDRAM Address.
    - a=data[6:0] valid if 0x00-0x27 or 0x40-0x67: addr=a.
    - Otherwise addr is unchanged and cmd_err pulses.
  - 01xxxxxx (CGRAM), 001xxxxx (function set), 0001xxxx (shift): accepted, no state change.
  - 00001DCB: display_on=D, cursor_on=C, blink_on=B.
  - 000001IS: inc_mode=I; S ignored.
  - 0000001x: home, addr=0.
  - 00000001: clear, goes to CLEAR. Completion also sets addr=0 and inc_mode=1.
  - 0x00: no-op.
- Data write (RS=1):
  - DDRAM[phys(addr)]=data, last_char=data, char_valid pulses the next cycle, then addr steps.
  - phys(a) = a for a<0x40, otherwise a-0x40+40.
- Address step and wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Busy collision: a transfer detected while busy (CLEAR or EXEC) is discarded, ovf_err pulses, and the FSM and counter are unaffected.
- Timing: transfer at edge N sets busy=1 and the register updates visible after edge N. busy returns to 0 after edge N+BUSY_CYCLES.
- Read port: the rd_data register updates every cycle from rd_addr. During CLEAR the read reflects the pre-write value of that cycle (read-before-write). rd_addr >= 80 returns 0x00.

Test Plan:
- Reset, then hold rst low -> busy=1 for exactly 80 cycles; then rd_addr 0..79 all read 0x20; addr=0x00.
- Commands 0x38, 0x0E, 0x01, 0x02 (driver init), each EN pulse spaced beyond busy:
  - after 0x0E: display_on=1, cursor_on=1, blink_on=0.
  - 0x01 gives 80 busy cycles.
  - final addr=0x00.
- RS=1 writes 0x4C, 0x4F, 0x41, 0x44:
  - DDRAM[0..3] = "LOAD", addr=0x04.
  - char_valid pulses 4 times; last_char=0x44.
- Wrap:
  - cmd 0xA7 (addr 0x27), write 0x31 -> DDRAM[39]=0x31, addr=0x40.
  - cmd 0xE7, write 0x32 -> DDRAM[79]=0x32, addr=0x00.
  - cmd 0x04 then write at 0x40 -> addr=0x27.
- Errors:
  - EN falling edge one cycle after a data write (busy) -> ovf_err pulse, DDRAM and addr unchanged.
  - cmd 0xB0 (0x30 unmapped) -> cmd_err pulse, addr unchanged.
- Reset asserted at cycle 20 of a clear -> CLEAR restarts from index 0; busy high 80 more cycles; all control outputs at reset values.
